// File: rtl/pe_relay_fifo.sv
// rtl/pe_relay_fifo.sv - multi-channel elastic pass-through relay with occupancy and stall statistics
module pe_relay_fifo #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 130,
    parameter int DEPTH      = 4,
    parameter int ADDR_BITS  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ap_start,
    input  logic                              clr_stats,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      in_data,
    input  logic [NUM_CH-1:0]                 in_valid,
    output logic [NUM_CH-1:0]                 in_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]      out_data,
    output logic [NUM_CH-1:0]                 out_valid,
    input  logic [NUM_CH-1:0]                 out_ready,
    output logic [NUM_CH*(ADDR_BITS+1)-1:0]   occupancy,
    output logic [NUM_CH*CNT_WIDTH-1:0]       stall_cnt
);

    localparam int OCC_W = ADDR_BITS + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d    [NUM_CH][DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_q [NUM_CH];
    logic [ADDR_BITS-1:0]  wr_ptr_d [NUM_CH];
    logic [ADDR_BITS-1:0]  rd_ptr_q [NUM_CH];
    logic [ADDR_BITS-1:0]  rd_ptr_d [NUM_CH];
    logic [OCC_W-1:0]      occ_q    [NUM_CH];
    logic [OCC_W-1:0]      occ_d    [NUM_CH];
    logic [CNT_WIDTH-1:0]  stall_q  [NUM_CH];
    logic [CNT_WIDTH-1:0]  stall_d  [NUM_CH];

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    // Handshake outputs and export views; head word is forced to zero when empty so it is never X.
    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_data  = '0;
        occupancy = '0;
        stall_cnt = '0;
        push      = '0;
        pop       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c]  = !reset && (occ_q[c] != OCC_FULL);
            out_valid[c] = !reset && ap_start && (occ_q[c] != '0);
            push[c]      = in_valid[c] && in_ready[c];
            pop[c]       = out_valid[c] && out_ready[c];
            if (occ_q[c] != '0) begin
                out_data[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[c][rd_ptr_q[c]];
            end
            occupancy[c*OCC_W +: OCC_W]         = occ_q[c];
            stall_cnt[c*CNT_WIDTH +: CNT_WIDTH] = stall_q[c];
        end
    end

    // Next-state for pointers, occupancy, storage and the saturating stall counters.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        stall_d  = stall_q;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + ADDR_BITS'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + ADDR_BITS'(pop[c]);
            occ_d[c]    = occ_q[c] + OCC_W'(push[c]) - OCC_W'(pop[c]);
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (clr_stats) begin
                stall_d[c] = '0;
            end else if ((occ_q[c] != '0) && ap_start && !out_ready[c] && (stall_q[c] != '1)) begin
                stall_d[c] = stall_q[c] + CNT_WIDTH'(1);
            end
        end
    end

    // Control state register; reset discards buffered data by clearing pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            occ_q    <= '{default: '0};
            stall_q  <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pe_relay_fifo.sv
// tb/tb_pe_relay_fifo.sv - randomized self-checking bench for pe_relay_fifo against a queue model
module tb_pe_relay_fifo;

    localparam int NC    = 3;
    localparam int DW    = 130;
    localparam int DEPTH = 4;
    localparam int AB    = 2;
    localparam int CW    = 4;
    localparam int OW    = AB + 1;
    localparam int SMAX  = (1 << CW) - 1;

    typedef logic [DW-1:0] word_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 ap_start = 1'b0;
    logic                 clr_stats = 1'b0;
    logic [NC*DW-1:0]     in_data = '0;
    logic [NC-1:0]        in_valid = '0;
    logic [NC-1:0]        in_ready;
    logic [NC*DW-1:0]     out_data;
    logic [NC-1:0]        out_valid;
    logic [NC-1:0]        out_ready = '0;
    logic [NC*OW-1:0]     occupancy;
    logic [NC*CW-1:0]     stall_cnt;

    pe_relay_fifo #(
        .NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .clr_stats(clr_stats),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_pass  = 0;
    word_t mq [NC][$];
    int    mst [NC];
    bit    known = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic word_t rand_word();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NC*DW-1:0] put(input int c, input word_t w);
        logic [NC*DW-1:0] v = '0;
        v[c*DW +: DW] = w;
        return v;
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model for the coming edge.
    task automatic cycle(input logic rst, input logic aps, input logic clr,
                         input logic [NC-1:0] iv, input logic [NC-1:0] ordy,
                         input logic [NC*DW-1:0] din, output logic [NC-1:0] acc);
        int    sz;
        logic  e_ir, e_ov, p;
        word_t head;
        @(negedge clk);
        reset = rst; ap_start = aps; clr_stats = clr;
        in_valid = iv; out_ready = ordy; in_data = din;
        #1;
        acc = '0;
        for (int c = 0; c < NC; c++) begin
            sz   = mq[c].size();
            e_ir = !rst && (sz < DEPTH);
            e_ov = !rst && aps && (sz > 0);
            head = (sz > 0) ? mq[c][0] : '0;
            chk($sformatf("ch%0d in_ready", c), DW'(in_ready[c]), DW'(e_ir));
            chk($sformatf("ch%0d out_valid", c), DW'(out_valid[c]), DW'(e_ov));
            if (known) begin
                chk($sformatf("ch%0d occupancy", c), DW'(occupancy[c*OW +: OW]), DW'(sz));
                chk($sformatf("ch%0d out_data", c), out_data[c*DW +: DW], head);
                chk($sformatf("ch%0d stall_cnt", c), DW'(stall_cnt[c*CW +: CW]), DW'(mst[c]));
            end
            acc[c] = iv[c] && e_ir;
            p      = e_ov && ordy[c];
            if (rst) begin
                mq[c].delete();
                mst[c] = 0;
            end else begin
                if (clr) mst[c] = 0;
                else if (sz > 0 && aps && !ordy[c] && mst[c] < SMAX) mst[c]++;
                if (p) void'(mq[c].pop_front());
                if (acc[c]) mq[c].push_back(din[c*DW +: DW]);
            end
        end
        if (rst) known = 1'b1;
    endtask

    initial begin
        logic [NC-1:0]    acc;
        logic [NC*DW-1:0] din;
        word_t            w5;
        bit               pending;
        int               sent, budget;

        for (int c = 0; c < NC; c++) mst[c] = 0;
        cycle(1, 0, 0, '0, '0, '0, acc);
        cycle(1, 1, 0, '1, '1, '0, acc);

        // Back-to-back A,B,C through ch0 with drain enabled.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 3'b001, 3'b111, put(0, rand_word()), acc);
            chk("s1 accept", DW'(acc[0]), DW'(1));
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0, 3'b111, '0, acc);

        // Prefill ch1 while stopped, fifth word waits until drain frees a slot.
        for (int i = 0; i < 5; i++) begin
            w5 = rand_word();
            cycle(0, 0, 0, 3'b010, '0, put(1, w5), acc);
            chk("s2 accept", DW'(acc[1]), DW'(i < 4));
        end
        pending = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, pending ? 3'b010 : 3'b000, 3'b010, put(1, w5), acc);
            if (acc[1]) pending = 1'b0;
        end
        chk("s2 fifth accepted", DW'(pending), DW'(0));

        // Full ch2: same-cycle push and pop must reject the push.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 3'b100, '0, put(2, rand_word()), acc);
        cycle(0, 1, 0, 3'b100, 3'b100, put(2, rand_word()), acc);
        chk("s3 push at full", DW'(acc[2]), DW'(0));
        cycle(0, 0, 0, '0, '0, '0, acc);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, '1, '0, acc);

        // Stall counting, saturation and clear on ch0.
        cycle(0, 0, 1, 3'b001, '0, put(0, rand_word()), acc);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, '0, 3'b110, '0, acc);
        @(posedge clk); #1;
        chk("s4 stall 10", DW'(stall_cnt[CW-1:0]), DW'(10));
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, '0, 3'b110, '0, acc);
        @(posedge clk); #1;
        chk("s4 stall sat", DW'(stall_cnt[CW-1:0]), DW'(SMAX));
        cycle(0, 1, 1, '0, 3'b110, '0, acc);
        @(posedge clk); #1;
        chk("s4 stall clr", DW'(stall_cnt[CW-1:0]), DW'(0));
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, '0, '1, '0, acc);

        // Pointer wrap: incrementing stream through ch0 with random backpressure.
        sent = 0; budget = 0;
        while ((sent < 3*DEPTH+1 || mq[0].size() > 0) && budget < 300) begin
            cycle(0, 1, 0, (sent < 3*DEPTH+1) ? 3'b001 : 3'b000,
                  {2'b11, 1'($urandom_range(0, 1))}, put(0, word_t'(100 + sent)), acc);
            if (acc[0]) sent++;
            budget++;
        end
        chk("s5 words sent", DW'(sent), DW'(3*DEPTH+1));
        chk("s5 drained", DW'(mq[0].size()), DW'(0));

        // Reset with all channels half full, then a fresh word must come out intact.
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NC; c++) din[c*DW +: DW] = rand_word();
            cycle(0, 0, 0, '1, '0, din, acc);
        end
        cycle(1, 0, 0, '0, '0, '0, acc);
        cycle(0, 0, 0, '0, '0, '0, acc);
        chk("s6 occ after reset", DW'(occupancy), DW'(0));
        cycle(0, 1, 0, 3'b001, '1, put(0, rand_word()), acc);
        cycle(0, 1, 0, '0, '1, '0, acc);

        // Random traffic on all channels.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NC; c++) din[c*DW +: DW] = rand_word();
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 29) == 0), NC'($urandom), NC'($urandom), din, acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
